// File: rtl/frame_pkg.sv
// Shared frame-format definitions for the line-side frame mapper and the
// receiver demapper: geometry, column bounds, FAS byte values and a helper
// that classifies a (row, col) position into the kind of byte it carries.
package frame_pkg;

  localparam int P_ROWS    = 4;
  localparam int P_COLS    = 1041;
  localparam int P_OH_COLS = 16;

  localparam int ROW_W = 2;
  localparam int COL_W = 11;

  localparam logic [ROW_W-1:0] ROW_LAST = 2'd3;
  localparam logic [COL_W-1:0] COL_LAST = 11'd1040;

  localparam logic [COL_W-1:0] PYLD_COL_FIRST = 11'd16;
  localparam logic [COL_W-1:0] PYLD_COL_LAST  = 11'd1039;
  localparam logic [COL_W-1:0] STUFF_COL      = 11'd1040;
  localparam logic [COL_W-1:0] ARQ_COL        = 11'd6;

  // FAS occupies row 0: three bytes of FAS_BYTE_A then three of FAS_BYTE_B.
  localparam logic [COL_W-1:0] FAS_A_LAST_COL = 11'd2;
  localparam logic [COL_W-1:0] FAS_B_LAST_COL = 11'd5;
  localparam logic [7:0]       FAS_BYTE_A     = 8'hF6;
  localparam logic [7:0]       FAS_BYTE_B     = 8'h28;
  localparam logic [7:0]       ARQ_ON_BYTE    = 8'hFF;
  localparam logic [7:0]       ZERO_BYTE      = 8'h00;

  typedef enum logic [2:0] {
    COL_FAS_A = 3'd0,
    COL_FAS_B = 3'd1,
    COL_ARQ   = 3'd2,
    COL_OH    = 3'd3,
    COL_PYLD  = 3'd4,
    COL_STUFF = 3'd5
  } col_class_e;

  function automatic logic is_pyld_col(input logic [COL_W-1:0] col);
    return (col >= PYLD_COL_FIRST) && (col <= PYLD_COL_LAST);
  endfunction

  function automatic col_class_e col_class(input logic [ROW_W-1:0] row,
                                           input logic [COL_W-1:0] col);
    col_class_e cls;
    if (is_pyld_col(col)) begin
      cls = COL_PYLD;
    end else if (col == STUFF_COL) begin
      cls = COL_STUFF;
    end else if ((row == 2'd0) && (col <= FAS_A_LAST_COL)) begin
      cls = COL_FAS_A;
    end else if ((row == 2'd0) && (col <= FAS_B_LAST_COL)) begin
      cls = COL_FAS_B;
    end else if ((row == 2'd0) && (col == ARQ_COL)) begin
      cls = COL_ARQ;
    end else begin
      cls = COL_OH;
    end
    return cls;
  endfunction

endpackage

// File: rtl/frame_pos_cnt.sv
// Row/column position counter for the frame mapper. Holds the position of
// the next byte to emit; advances by one column when i_adv is high, wrapping
// the last column to 0 with a row increment and the last row back to 0.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_adv          : advance the position this cycle
//   o_row, o_col   : current position (registered)
module frame_pos_cnt
  import frame_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_adv,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Next position: increment column, wrap into the next row at the end.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (i_adv) begin
      if (col_q == COL_LAST) begin
        col_d = 11'd0;
        if (row_q == ROW_LAST) begin
          row_d = 2'd0;
        end else begin
          row_d = row_q + 2'd1;
        end
      end else begin
        col_d = col_q + 11'd1;
        row_d = row_q;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Position register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_q <= 2'd0;
      col_q <= 11'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign o_row = row_q;
  assign o_col = col_q;

endmodule

// File: rtl/frame_map.sv
// Frame mapper: builds the 4 x 1041 line frame from FAS/ARQ overhead, the
// client payload stream and a stuff column, and presents it one byte per
// emit cycle on a registered output with its row/column tag.
// Ports:
//   i_clk, i_rst_n                       : clock, asynchronous active-low reset
//   i_pyld_data/_valid, o_pyld_data_ready : client byte stream handshake
//   i_arq_en, i_arq_en_valid              : ARQ enable and its qualifier
//   i_line_ready                          : line side can take a byte
//   o_frame_data/_valid/_fas              : line byte, valid, frame-start flag
//   o_row_cnt, o_col_cnt                  : position of the byte on o_frame_data
module frame_map
  import frame_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_pyld_data,
  input  logic             i_pyld_data_valid,
  output logic             o_pyld_data_ready,
  input  logic             i_arq_en,
  input  logic             i_arq_en_valid,
  input  logic             i_line_ready,
  output logic [7:0]       o_frame_data,
  output logic             o_frame_data_valid,
  output logic             o_frame_data_fas,
  output logic [ROW_W-1:0] o_row_cnt,
  output logic [COL_W-1:0] o_col_cnt
);

  logic [ROW_W-1:0] pos_row_s;
  logic [COL_W-1:0] pos_col_s;
  logic             pyld_col_s;
  logic             emit_s;
  logic             arq_eff_s;
  logic [7:0]       byte_s;
  col_class_e       cls_s;

  logic             arq_en_q, arq_en_d;
  logic [7:0]       frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             fas_q, fas_d;
  logic [ROW_W-1:0] row_out_q, row_out_d;
  logic [COL_W-1:0] col_out_q, col_out_d;

  frame_pos_cnt u_pos (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_adv   (emit_s),
    .o_row   (pos_row_s),
    .o_col   (pos_col_s)
  );

  // Ready depends only on the registered position and line back-pressure, so
  // the client may wait for ready before raising valid without deadlock.
  assign pyld_col_s        = is_pyld_col(pos_col_s);
  assign o_pyld_data_ready = i_line_ready & pyld_col_s;
  // Overhead and stuff columns never wait on the client.
  assign emit_s            = i_line_ready & (~pyld_col_s | i_pyld_data_valid);
  assign cls_s             = col_class(pos_row_s, pos_col_s);

  // Byte selection and ARQ latch; a same-cycle ARQ update bypasses the latch.
  always_comb begin
    arq_eff_s = arq_en_q;
    arq_en_d  = arq_en_q;
    byte_s    = ZERO_BYTE;
    if (i_arq_en_valid) begin
      arq_eff_s = i_arq_en;
      arq_en_d  = i_arq_en;
    end else begin
      arq_eff_s = arq_en_q;
      arq_en_d  = arq_en_q;
    end
    case (cls_s)
      COL_FAS_A: byte_s = FAS_BYTE_A;
      COL_FAS_B: byte_s = FAS_BYTE_B;
      COL_ARQ:   byte_s = arq_eff_s ? ARQ_ON_BYTE : ZERO_BYTE;
      COL_PYLD:  byte_s = i_pyld_data;
      COL_STUFF: byte_s = ZERO_BYTE;
      COL_OH:    byte_s = ZERO_BYTE;
      default:   byte_s = ZERO_BYTE;
    endcase
  end

  // Output stage: capture the byte and its tag on emit, otherwise hold.
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    fas_d         = 1'b0;
    row_out_d     = row_out_q;
    col_out_d     = col_out_q;
    if (emit_s) begin
      frame_data_d  = byte_s;
      frame_valid_d = 1'b1;
      fas_d         = (pos_row_s == 2'd0) && (pos_col_s == 11'd0);
      row_out_d     = pos_row_s;
      col_out_d     = pos_col_s;
    end else begin
      frame_data_d  = frame_data_q;
      frame_valid_d = 1'b0;
      fas_d         = 1'b0;
      row_out_d     = row_out_q;
      col_out_d     = col_out_q;
    end
  end

  // Output and ARQ registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arq_en_q      <= 1'b0;
      frame_data_q  <= 8'h00;
      frame_valid_q <= 1'b0;
      fas_q         <= 1'b0;
      row_out_q     <= 2'd0;
      col_out_q     <= 11'd0;
    end else begin
      arq_en_q      <= arq_en_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      fas_q         <= fas_d;
      row_out_q     <= row_out_d;
      col_out_q     <= col_out_d;
    end
  end

  assign o_frame_data       = frame_data_q;
  assign o_frame_data_valid = frame_valid_q;
  assign o_frame_data_fas   = fas_q;
  assign o_row_cnt          = row_out_q;
  assign o_col_cnt          = col_out_q;

endmodule
